// File: rtl/frame_stream_reader.sv
// frame_stream_reader: sweeps one ping-pong buffer half per frame-ready edge and streams it out
// with sop/eop markers, tracking the frame's peak |sample| and flagging overlapping frame starts.
module frame_stream_reader #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 10,
    parameter int RD_LAT    = 1
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 frame_start_i,
    output logic [ADDR_BITS-1:0] buf_raddr_o,
    input  logic [DATA_BITS-1:0] buf_rdata_i,
    output logic [DATA_BITS-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_sop_o,
    output logic                 m_eop_o,
    output logic                 busy_o,
    output logic [DATA_BITS-1:0] peak_o,
    output logic                 peak_valid_o,
    output logic                 overrun_o
);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_next;

    logic                 start_q, start_evt, issue, capture, fire, last;
    logic [ADDR_BITS:0]   issue_cnt;
    logic [ADDR_BITS-1:0] acc_cnt, raddr_q;
    logic [RD_LAT-1:0]    rd_pipe;
    logic [CW-1:0]        occ, infl;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mag, run_max, max_next;

    assign start_evt = frame_start_i & ~start_q;
    assign busy_o    = state == STREAM;
    // Reads are issued only against free FIFO slots, so returning data always has room.
    assign issue       = busy_o && !issue_cnt[ADDR_BITS] && ({1'b0, occ} + {1'b0, infl}) < DEPTH_W;
    assign capture     = rd_pipe[RD_LAT-1];
    assign buf_raddr_o = issue ? issue_cnt[ADDR_BITS-1:0] : raddr_q;
    assign m_valid_o   = occ != '0;
    assign m_data_o    = m_valid_o ? mem[rd_ptr] : '0;
    assign fire        = m_valid_o & m_ready_i;
    assign m_sop_o     = m_valid_o && acc_cnt == '0;
    assign m_eop_o     = m_valid_o && &acc_cnt;
    assign last        = fire & m_eop_o;
    assign mag         = m_data_o[DATA_BITS-1] ? ~m_data_o + DATA_BITS'(1) : m_data_o;
    assign max_next    = mag > run_max ? mag : run_max;

    always_comb begin
        state_next = state;
        if (state == IDLE && start_evt) state_next = STREAM;
        else if (last) state_next = IDLE;
    end

    always_ff @(posedge mclk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;

    always_ff @(posedge mclk)
        if (capture) mem[wr_ptr] <= buf_rdata_i;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            issue_cnt    <= '0;
            acc_cnt      <= '0;
            raddr_q      <= '0;
            rd_pipe      <= '0;
            occ          <= '0;
            infl         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            run_max      <= '0;
            peak_o       <= '0;
            peak_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            start_q      <= frame_start_i;
            peak_valid_o <= last;
            overrun_o    <= start_evt && busy_o;
            rd_pipe      <= (rd_pipe << 1) | RD_LAT'(issue);
            occ          <= occ + CW'(capture) - CW'(fire);
            if (state == IDLE && start_evt) begin
                issue_cnt <= '0;
                acc_cnt   <= '0;
                infl      <= '0;
                run_max   <= '0;
            end else begin
                infl <= infl + CW'(issue) - CW'(capture);
                if (issue) begin
                    issue_cnt <= issue_cnt + (ADDR_BITS+1)'(1);
                    raddr_q   <= issue_cnt[ADDR_BITS-1:0];
                end
                if (fire) begin
                    acc_cnt <= acc_cnt + ADDR_BITS'(1);
                    run_max <= max_next;
                end
            end
            if (capture) wr_ptr <= wr_ptr == LAST_PTR ? '0 : wr_ptr + PW'(1);
            if (fire) rd_ptr <= rd_ptr == LAST_PTR ? '0 : rd_ptr + PW'(1);
            if (last) peak_o <= max_next;
        end
    end
endmodule

// File: tb/tb_frame_stream_reader.sv
// tb_frame_stream_reader: directed frames against two readers (RD_LAT=1 with ready high,
// RD_LAT=3 with random ready) sharing frame_start, reset and the buffer contents.
module tb_frame_stream_reader;
    logic mclk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic clr = 1'b0;
    always #5 mclk = ~mclk;

    logic [15:0] frame [1024];
    logic [9:0]  a1, a3;
    logic [15:0] rd1, rd3, d1, d3, pk1, pk3, p3a, p3b;
    logic        v1, v3, s1, s3, e1, e3, b1, b3, pv1, pv3, ov1, ov3;
    logic        r1 = 1'b1;
    logic        r3 = 1'b1;
    int errors = 0, checks = 0;
    int beats1, bad1, ovc1, pvc1, beats3, bad3, ovc3, pvc3;
    int max_occ = 0;

    frame_stream_reader #(.DATA_BITS(16), .ADDR_BITS(10), .RD_LAT(1)) u1 (
        .mclk(mclk), .rst_n(rst_n), .frame_start_i(frame_start), .buf_raddr_o(a1),
        .buf_rdata_i(rd1), .m_data_o(d1), .m_valid_o(v1), .m_ready_i(r1), .m_sop_o(s1),
        .m_eop_o(e1), .busy_o(b1), .peak_o(pk1), .peak_valid_o(pv1), .overrun_o(ov1));

    frame_stream_reader #(.DATA_BITS(16), .ADDR_BITS(10), .RD_LAT(3)) u3 (
        .mclk(mclk), .rst_n(rst_n), .frame_start_i(frame_start), .buf_raddr_o(a3),
        .buf_rdata_i(rd3), .m_data_o(d3), .m_valid_o(v3), .m_ready_i(r3), .m_sop_o(s3),
        .m_eop_o(e3), .busy_o(b3), .peak_o(pk3), .peak_valid_o(pv3), .overrun_o(ov3));

    // Buffer models: one and three cycles from address to data.
    always @(posedge mclk) rd1 <= frame[a1];
    always @(posedge mclk) begin
        p3a <= frame[a3];
        p3b <= p3a;
        rd3 <= p3b;
    end

    initial forever begin
        @(posedge mclk);
        #1 r3 = 1'($urandom_range(0, 1));
    end

    always @(negedge mclk) begin
        if (clr) begin
            beats1 = 0; bad1 = 0; ovc1 = 0; pvc1 = 0;
            beats3 = 0; bad3 = 0; ovc3 = 0; pvc3 = 0;
        end else begin
            if (v1 && r1) begin
                if (d1 !== frame[beats1] || s1 !== (beats1 == 0) || e1 !== (beats1 == 1023)) bad1++;
                beats1++;
            end
            if (v3 && r3) begin
                if (d3 !== frame[beats3] || s3 !== (beats3 == 0) || e3 !== (beats3 == 1023)) bad3++;
                beats3++;
            end
            ovc1 += int'(ov1); pvc1 += int'(pv1);
            ovc3 += int'(ov3); pvc3 += int'(pv3);
            if (int'(u3.occ) > max_occ) max_occ = int'(u3.occ);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic clear();
        clr = 1'b1;
        step(1);
        #1 clr = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((b1 || b3) && t < 20000) begin
            step(1);
            t++;
        end
        chk("idle_timeout", 32'(t < 20000), 1);
        step(3);
        #1;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beats1 < n && t < 5000) begin
            step(1);
            #1;
            t++;
        end
        chk("beat_timeout", 32'(t < 5000), 1);
    endtask

    task automatic frame_run(input int hold);
        clear();
        frame_start = 1'b1;
        step(hold);
        frame_start = 1'b0;
        wait_idle();
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_beats1"}, beats1, 1024);
        chk({tag, "_bad1"}, bad1, 0);
        chk({tag, "_beats3"}, beats3, 1024);
        chk({tag, "_bad3"}, bad3, 0);
    endtask

    initial begin
        int j;
        step(2);
        chk("rst_ctl1", {v1, s1, e1, b1, pv1, ov1}, 0);
        chk("rst_addr1", a1, 0);
        chk("rst_data1", d1, 0);
        chk("rst_peak1", pk1, 0);
        chk("rst_ctl3", {v3, s3, e3, b3, pv3, ov3}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) frame[i] = 16'(i);
        clear();

        // Ramp frame: exact start-up latency and frame length for RD_LAT=1.
        frame_start = 1'b1;
        step(1);
        chk("t0_busy", b1, 1);
        chk("t0_addr", a1, 0);
        chk("t0_valid", v1, 0);
        step(1);
        chk("t1_addr", a1, 1);
        chk("t1_valid", v1, 0);
        step(1);
        frame_start = 1'b0;
        chk("t2_valid", v1, 1);
        chk("t2_data", d1, 0);
        chk("t2_sop", s1, 1);
        j = 2;
        while (b1 && j < 3000) begin
            step(1);
            j++;
        end
        chk("frame_cycles", j, 1026);
        chk("peak_pulse", pv1, 1);
        chk("ramp_peak1", pk1, 1023);
        wait_idle();
        check_frame("ramp");
        chk("ramp_peak3", pk3, 1023);
        chk("ramp_pv1", pvc1, 1);
        chk("ramp_pv3", pvc3, 1);

        // Extremes: -32768 must report 0x8000, above +32767.
        for (int i = 0; i < 1024; i++) frame[i] = 16'h0000;
        frame[10] = 16'h8000;
        frame[20] = 16'h7fff;
        frame[30] = 16'hffff;
        frame_run(3);
        check_frame("ext");
        chk("ext_peak1", pk1, 16'h8000);
        chk("ext_peak3", pk3, 16'h8000);

        // All-zero frame with the start level held 40 cycles.
        frame[10] = 16'h0000;
        frame[20] = 16'h0000;
        frame[30] = 16'h0000;
        frame_run(40);
        check_frame("zero");
        chk("zero_peak1", pk1, 0);
        chk("zero_peak3", pk3, 0);
        chk("hold_ov1", ovc1, 0);
        chk("hold_ov3", ovc3, 0);
        chk("hold_pv1", pvc1, 1);

        // Second rising edge mid-frame is reported and ignored.
        for (int i = 0; i < 1024; i++) frame[i] = 16'(i * 40503 + 12345);
        clear();
        frame_start = 1'b1;
        step(3);
        frame_start = 1'b0;
        wait_beats(500);
        frame_start = 1'b1;
        step(3);
        frame_start = 1'b0;
        wait_idle();
        check_frame("ovr");
        chk("ovr_pulse1", ovc1, 1);
        chk("ovr_pulse3", ovc3, 1);
        step(5);
        #1;
        chk("ovr_no_second", {b1, b3}, 0);
        chk("ovr_beats_after", beats1, 1024);

        // Reset mid-frame, then a clean ramp frame.
        for (int i = 0; i < 1024; i++) frame[i] = 16'(i);
        clear();
        frame_start = 1'b1;
        step(3);
        frame_start = 1'b0;
        wait_beats(300);
        chk("pre_rst_busy", b1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl1", {v1, s1, e1, b1, pv1, ov1}, 0);
        chk("mid_rst_addr1", a1, 0);
        chk("mid_rst_data1", d1, 0);
        chk("mid_rst_peak1", pk1, 0);
        chk("mid_rst_ctl3", {v3, b3, pv3}, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        frame_run(2);
        check_frame("post");
        chk("post_peak1", pk1, 1023);
        chk("post_pv1", pvc1, 1);
        chk("post_ov1", ovc1, 0);
        chk("max_occ", 32'(max_occ <= 5), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
